// File: rtl/button_event_fsm_pkg.sv
// Shared definitions for button event consumers: FSM state encodings and tick timing.
package button_event_fsm_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StPressed = 2'b01,
        StLong    = 2'b10
    } btn_state_e;

    localparam int unsigned TickMs = 10;

endpackage

// File: rtl/button_event_fsm_edge_detect.sv
// Registers the previous level of d_i and flags single-cycle rise/fall against it.
module button_event_fsm_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_i;
        end
    end

    // prev_q resets low, so a level already high at reset release reads as a rise.
    assign rise_o = d_i & ~prev_q;
    assign fall_o = ~d_i & prev_q;

endmodule

// File: rtl/button_event_fsm.sv
// Turns a debounced button level into registered press/release/long/repeat pulses and a held level.
module button_event_fsm
    import button_event_fsm_pkg::*;
#(
    parameter int unsigned LongTicks   = 100,
    parameter int unsigned RepeatTicks = 20,
    parameter int unsigned CntW        = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic db_in_i,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic long_pulse_o,
    output logic repeat_pulse_o,
    output logic held_o
);

    localparam logic [CntW-1:0] LongLast   = CntW'(LongTicks - 1);
    localparam logic [CntW-1:0] RepeatLast = CntW'(RepeatTicks - 1);

    logic rise;
    logic fall;

    btn_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            press_q;
    logic            release_q;
    logic            long_q;
    logic            repeat_q;

    button_event_fsm_edge_detect u_edge_detect (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (db_in_i),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state_q)
                // A tick coinciding with the rise is deliberately not counted.
                StIdle: begin
                    if (rise) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                    end
                end
                StPressed: begin
                    if (fall) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                    end else if (tick_i) begin
                        if (cnt_q == LongLast) begin
                            state_q <= StLong;
                            cnt_q   <= '0;
                            long_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StLong: begin
                    if (fall) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                    end else if (tick_i) begin
                        if (cnt_q == RepeatLast) begin
                            cnt_q    <= '0;
                            repeat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign long_pulse_o    = long_q;
    assign repeat_pulse_o  = repeat_q;
    assign held_o          = (state_q == StPressed) || (state_q == StLong);

endmodule
